// File: rtl/mem_lbdif_seq_pkg.sv
// Shared types and constants for the local-bus interface sequencer and its delay line.
package mem_lbdif_pkg;

    localparam int unsigned CHANNELS_DEF = 10;
    localparam int unsigned TAPS_DEF     = 4;
    localparam int unsigned TAP_W        = $clog2(TAPS_DEF);
    localparam int unsigned CNT_W        = 5;
    localparam int unsigned STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_REFRESH = 3'd1,
        ST_BUS_ACC = 3'd2,
        ST_CPU_ACC = 3'd3,
        ST_WAIT    = 3'd4,
        ST_READY   = 3'd5,
        ST_RELEASE = 3'd6
    } lbdif_state_t;

    // Clamp a parameter-derived load value to the counter range
    function automatic logic [CNT_W-1:0] sat_cnt(input int unsigned v);
        return (v > ((1 << CNT_W) - 1)) ? '1 : CNT_W'(v);
    endfunction

endpackage

// File: rtl/mem_lbdif_seq_if.sv
// Arbiter-side handshake bundle between the local bus arbiter and the sequencer.
interface mem_lbdif_if;
    import mem_lbdif_pkg::*;

    logic               BGNT_n;
    logic               CGNT_n;
    logic               BDAP_n;
    logic               MWRITE_n;
    logic               REF_n;
    logic               MOR_n;
    logic               ECCR;
    logic               MR_n;
    logic               BDRY_n;
    logic               RDATA;
    logic               RDATA25;
    logic               BCGNT50R_n;
    logic               BUSY;
    logic [STATE_W-1:0] STATE;

    modport master (
        output BGNT_n, CGNT_n, BDAP_n, MWRITE_n, REF_n, MOR_n, ECCR, MR_n,
        input  BDRY_n, RDATA, RDATA25, BCGNT50R_n, BUSY, STATE
    );

    modport slave (
        input  BGNT_n, CGNT_n, BDAP_n, MWRITE_n, REF_n, MOR_n, ECCR, MR_n,
        output BDRY_n, RDATA, RDATA25, BCGNT50R_n, BUSY, STATE
    );
endinterface

// File: rtl/mem_lbdif_seq_delay_line.sv
// Multi-channel shift-register delay line with per-channel tap select and output gating.
module lbdif_delay_line
    import mem_lbdif_pkg::*;
#(
    parameter int unsigned CHANNELS = CHANNELS_DEF,
    parameter int unsigned TAPS     = TAPS_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_oe_n,
    input  logic [CHANNELS-1:0]                i_din,
    input  logic [CHANNELS*$clog2(TAPS)-1:0]   i_tap_sel,
    output logic [CHANNELS-1:0]                o_dout_c,
    output logic [CHANNELS*TAPS-1:0]           o_dtap_c
);

    localparam int unsigned SEL_W = $clog2(TAPS);

    logic [TAPS-1:0] r_taps [CHANNELS];

    // Out-of-range selects fall back to the deepest tap
    function automatic logic pick_tap(input logic [TAPS-1:0] taps, input logic [SEL_W-1:0] sel);
        logic [TAPS-1:0] shifted;
        int unsigned     idx;
        idx     = (32'(sel) >= TAPS) ? TAPS - 1 : 32'(sel);
        shifted = taps >> idx;
        return shifted[0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CHANNELS; c++) r_taps[c] <= '1;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) r_taps[c] <= {r_taps[c][TAPS-2:0], i_din[c]};
        end
    end

    // Taps keep shifting while the outputs are disabled
    always_comb begin
        o_dout_c = '1;
        o_dtap_c = '1;
        if (!i_oe_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                o_dout_c[c]              = pick_tap(r_taps[c], i_tap_sel[c*SEL_W +: SEL_W]);
                o_dtap_c[c*TAPS +: TAPS] = r_taps[c];
            end
        end
    end

endmodule

// File: rtl/mem_lbdif_seq.sv
// Local-bus interface control: delay line plus ready/read-data sequencer for bus and CPU memory accesses.
module mem_lbdif_seq
    import mem_lbdif_pkg::*;
#(
    parameter int unsigned CHANNELS = CHANNELS_DEF,
    parameter int unsigned TAPS     = TAPS_DEF,
    parameter int unsigned RDY_DLY  = 2,
    parameter int unsigned ECC_DLY  = 2,
    parameter int unsigned REF_HOLD = 1
) (
    input  logic                             sysclk,
    input  logic                             sys_rst,
    input  logic                             OE_n,
    input  logic [CHANNELS-1:0]              DIN,
    input  logic [CHANNELS*$clog2(TAPS)-1:0] TAP_SEL,
    output logic [CHANNELS-1:0]              DOUT,
    output logic [CHANNELS*TAPS-1:0]         DTAP,
    mem_lbdif_if.slave                       bus
);

    localparam logic [CNT_W-1:0] RDY_LOAD = sat_cnt(RDY_DLY - 1);
    localparam logic [CNT_W-1:0] ECC_LOAD = sat_cnt(RDY_DLY - 1 + ECC_DLY);
    localparam logic [CNT_W-1:0] REF_LOAD = sat_cnt(REF_HOLD);

    lbdif_state_t     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_owner_cpu, w_owner_nxt;
    logic             r_mwrite_n, w_mwrite_nxt;
    logic             r_bdry_n, w_bdry_n_nxt;
    logic             r_rdata, w_rdata_nxt;
    logic             r_rdata25;
    logic             r_bcgnt_n, w_bcgnt_n_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_grant_lost;

    lbdif_delay_line #(
        .CHANNELS (CHANNELS),
        .TAPS     (TAPS)
    ) u_delay_line (
        .clk       (sysclk),
        .rst       (sys_rst),
        .i_oe_n    (OE_n),
        .i_din     (DIN),
        .i_tap_sel (TAP_SEL),
        .o_dout_c  (DOUT),
        .o_dtap_c  (DTAP)
    );

    assign w_grant_lost = r_owner_cpu ? bus.CGNT_n : bus.BGNT_n;

    // State, datapath and registered outputs; master clear clears RDATA25 too
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_owner_cpu <= 1'b0;
            r_mwrite_n  <= 1'b1;
            r_bdry_n    <= 1'b1;
            r_rdata     <= 1'b0;
            r_rdata25   <= 1'b0;
            r_bcgnt_n   <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_owner_cpu <= w_owner_nxt;
            r_mwrite_n  <= w_mwrite_nxt;
            r_bdry_n    <= w_bdry_n_nxt;
            r_rdata     <= w_rdata_nxt;
            r_rdata25   <= bus.MR_n ? r_rdata : 1'b0;
            r_bcgnt_n   <= w_bcgnt_n_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and counter
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_owner_nxt  = r_owner_cpu;
        w_mwrite_nxt = r_mwrite_n;
        unique case (r_state)
            ST_IDLE: begin
                if (!bus.REF_n) begin
                    w_state_nxt = ST_REFRESH;
                    w_cnt_nxt   = REF_LOAD;
                end else if (!bus.CGNT_n) begin
                    w_state_nxt = ST_CPU_ACC;
                    w_owner_nxt = 1'b1;
                end else if (!bus.BGNT_n && !bus.BDAP_n && bus.MOR_n) begin
                    w_state_nxt = ST_BUS_ACC;
                    w_owner_nxt = 1'b0;
                end
            end
            ST_REFRESH: begin
                if (!bus.REF_n)         w_cnt_nxt   = REF_LOAD;
                else if (r_cnt == '0)   w_state_nxt = ST_IDLE;
                else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            ST_BUS_ACC, ST_CPU_ACC: begin
                if (w_grant_lost) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt  = ST_WAIT;
                    w_mwrite_nxt = bus.MWRITE_n;
                    w_cnt_nxt    = bus.ECCR ? ECC_LOAD : RDY_LOAD;
                end
            end
            ST_WAIT: begin
                if (w_grant_lost)       w_state_nxt = ST_IDLE;
                else if (r_cnt == '0)   w_state_nxt = ST_READY;
                else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            ST_READY:   w_state_nxt = ST_RELEASE;
            ST_RELEASE: if (w_grant_lost) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (!bus.MR_n) w_state_nxt = ST_IDLE;
    end

    // Outputs decoded from the next state so they align with the state register
    always_comb begin
        w_bdry_n_nxt  = 1'b1;
        w_rdata_nxt   = 1'b0;
        w_bcgnt_n_nxt = 1'b1;
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
        case (w_state_nxt)
            ST_WAIT: w_bcgnt_n_nxt = !w_owner_nxt;
            ST_READY: begin
                w_bdry_n_nxt  = w_owner_nxt;
                w_rdata_nxt   = w_mwrite_nxt;
                w_bcgnt_n_nxt = !w_owner_nxt;
            end
            ST_RELEASE: begin
                w_rdata_nxt   = w_mwrite_nxt;
                w_bcgnt_n_nxt = !w_owner_nxt;
            end
            default: ;
        endcase
    end

    assign bus.BDRY_n     = r_bdry_n;
    assign bus.RDATA      = r_rdata;
    assign bus.RDATA25    = r_rdata25;
    assign bus.BCGNT50R_n = r_bcgnt_n;
    assign bus.BUSY       = r_busy;
    assign bus.STATE      = r_state;

endmodule

// File: tb/tb_mem_lbdif_seq.sv
// Directed bench for mem_lbdif_seq: delay line taps, access sequencing, priority, abort and clears.
module tb_mem_lbdif_seq;

    localparam int unsigned CH = 10;
    localparam int unsigned TP = 4;
    localparam int unsigned SW = 2;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic              OE_n;
    logic [CH-1:0]     DIN;
    logic [CH*SW-1:0]  TAP_SEL;
    logic [CH-1:0]     DOUT;
    logic [CH*TP-1:0]  DTAP;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_lbdif_if bus();

    mem_lbdif_seq #(
        .CHANNELS (CH),
        .TAPS     (TP),
        .RDY_DLY  (2),
        .ECC_DLY  (2),
        .REF_HOLD (1)
    ) dut (
        .sysclk  (clk),
        .sys_rst (sys_rst),
        .OE_n    (OE_n),
        .DIN     (DIN),
        .TAP_SEL (TAP_SEL),
        .DOUT    (DOUT),
        .DTAP    (DTAP),
        .bus     (bus)
    );

    // Observed vector: {STATE, BDRY_n, RDATA, RDATA25, BCGNT50R_n, BUSY}
    function automatic logic [7:0] obs();
        return {bus.STATE, bus.BDRY_n, bus.RDATA, bus.RDATA25, bus.BCGNT50R_n, bus.BUSY};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.BGNT_n = 1'b1; bus.CGNT_n = 1'b1; bus.BDAP_n = 1'b1; bus.MWRITE_n = 1'b1;
        bus.REF_n  = 1'b1; bus.MOR_n  = 1'b1; bus.ECCR   = 1'b0; bus.MR_n     = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; OE_n = 1'b0; DIN = '1; TAP_SEL = '0;
        bus_idle();
        tick(); tick();
        n_checks++;
        if (obs() !== 8'b000_10010) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs(), 8'b000_10010);
        end
        n_checks++;
        if (DTAP !== {(CH*TP){1'b1}}) begin
            n_fail++; $display("FAIL reset_taps: got %h expected all ones", DTAP);
        end
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_delay_line();
        logic [2:0] exp_d [5];
        exp_d = '{3'b110, 3'b101, 3'b111, 3'b011, 3'b111};
        TAP_SEL = '0; TAP_SEL[3:2] = 2'd1; TAP_SEL[5:4] = 2'd3;
        DIN = '1; DIN[2:0] = 3'b000;
        tick();
        DIN = '1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (DOUT[2:0] !== exp_d[k]) begin
                n_fail++; $display("FAIL dl_delay cycle %0d: got %b expected %b", k + 1, DOUT[2:0], exp_d[k]);
            end
            if (k == 0) begin
                n_checks++;
                if (DOUT[CH-1:3] !== '1 || DTAP[0] !== 1'b0) begin
                    n_fail++; $display("FAIL dl_other: dout=%b dtap0=%b expected ones/0", DOUT, DTAP[0]);
                end
            end
            tick();
        end
        // Output enable gates both DOUT and DTAP without stopping the shift
        DIN[0] = 1'b0;
        tick();
        DIN = '1; OE_n = 1'b1;
        #1;
        n_checks++;
        if (DOUT !== '1 || DTAP !== '1) begin
            n_fail++; $display("FAIL dl_oe_high: dout=%b dtap=%h expected all ones", DOUT, DTAP);
        end
        OE_n = 1'b0;
        #1;
        n_checks++;
        if (DOUT[0] !== 1'b0 || DTAP[0] !== 1'b0) begin
            n_fail++; $display("FAIL dl_oe_low: dout0=%b dtap0=%b expected 0/0", DOUT[0], DTAP[0]);
        end
        repeat (5) tick();
    endtask

    task automatic test_bus_read();
        logic [7:0] exp_v [8];
        exp_v = '{8'b010_10011, 8'b100_10011, 8'b100_10011, 8'b101_01011,
                  8'b110_11111, 8'b110_11111, 8'b000_10110, 8'b000_10010};
        bus.BGNT_n = 1'b0; bus.BDAP_n = 1'b0; bus.MWRITE_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (obs() !== exp_v[k]) begin
                n_fail++; $display("FAIL bus_read cycle %0d: got %b expected %b", k + 1, obs(), exp_v[k]);
            end
            if (k == 5) begin bus.BGNT_n = 1'b1; bus.BDAP_n = 1'b1; end
        end
    endtask

    task automatic test_ecc_cpu_write();
        logic [7:0] exp_v [9];
        exp_v = '{8'b011_10011, 8'b100_10001, 8'b100_10001, 8'b100_10001, 8'b100_10001,
                  8'b101_10001, 8'b110_10001, 8'b110_10001, 8'b000_10010};
        bus.CGNT_n = 1'b0; bus.ECCR = 1'b1; bus.MWRITE_n = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            n_checks++;
            if (obs() !== exp_v[k]) begin
                n_fail++; $display("FAIL ecc_cpu_write cycle %0d: got %b expected %b", k + 1, obs(), exp_v[k]);
            end
            if (k == 1) bus.ECCR = 1'b0;
            if (k == 7) begin bus.CGNT_n = 1'b1; bus.MWRITE_n = 1'b1; end
        end
    endtask

    task automatic test_priority();
        logic [7:0] exp_v [7];
        exp_v = '{8'b001_10011, 8'b001_10011, 8'b001_10011, 8'b000_10010,
                  8'b011_10011, 8'b000_10010, 8'b000_10010};
        bus.REF_n = 1'b0; bus.CGNT_n = 1'b0; bus.BGNT_n = 1'b0; bus.BDAP_n = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            n_checks++;
            if (obs() !== exp_v[k]) begin
                n_fail++; $display("FAIL priority cycle %0d: got %b expected %b", k + 1, obs(), exp_v[k]);
            end
            if (k == 1) bus.REF_n = 1'b1;
            if (k == 4) begin bus.CGNT_n = 1'b1; bus.BGNT_n = 1'b1; bus.BDAP_n = 1'b1; end
        end
    endtask

    task automatic test_abort_wait();
        logic [7:0] exp_v [6];
        exp_v = '{8'b010_10011, 8'b100_10011, 8'b000_10010, 8'b000_10010, 8'b000_10010, 8'b000_10010};
        bus.BGNT_n = 1'b0; bus.BDAP_n = 1'b0; bus.MWRITE_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (obs() !== exp_v[k]) begin
                n_fail++; $display("FAIL abort_wait cycle %0d: got %b expected %b", k + 1, obs(), exp_v[k]);
            end
            if (k == 1) begin bus.BGNT_n = 1'b1; bus.BDAP_n = 1'b1; end
        end
    endtask

    task automatic test_mem_off();
        bus.MOR_n = 1'b0; bus.BGNT_n = 1'b0; bus.BDAP_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (obs() !== 8'b000_10010) begin
                n_fail++; $display("FAIL mem_off cycle %0d: got %b expected %b", k + 1, obs(), 8'b000_10010);
            end
        end
        bus_idle();
        tick();
    endtask

    // use_mr selects master clear instead of sys_rst while in READY
    task automatic test_clear_in_ready(input bit use_mr);
        logic [7:0] exp_v [5];
        exp_v = '{8'b010_10011, 8'b100_10011, 8'b100_10011, 8'b101_01011, 8'b000_10010};
        bus.BGNT_n = 1'b0; bus.BDAP_n = 1'b0; bus.MWRITE_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (obs() !== exp_v[k]) begin
                n_fail++;
                $display("FAIL clear_in_ready(mr=%0d) cycle %0d: got %b expected %b", use_mr, k + 1, obs(), exp_v[k]);
            end
            if (k == 3) begin
                if (use_mr) bus.MR_n = 1'b0;
                else        sys_rst  = 1'b1;
            end
        end
        sys_rst = 1'b0;
        bus_idle();
        tick();
    endtask

    task automatic test_dl_clear();
        DIN = '0;
        repeat (4) tick();
        n_checks++;
        if (DTAP !== '0) begin
            n_fail++; $display("FAIL dl_fill: got %h expected all zeros", DTAP);
        end
        bus.MR_n = 1'b0;
        tick();
        n_checks++;
        if (DTAP !== '0 || bus.STATE !== 3'd0) begin
            n_fail++; $display("FAIL dl_after_mr: dtap=%h state=%0d expected zeros/0", DTAP, bus.STATE);
        end
        bus.MR_n = 1'b1; sys_rst = 1'b1;
        tick();
        n_checks++;
        if (DTAP !== '1) begin
            n_fail++; $display("FAIL dl_after_rst: got %h expected all ones", DTAP);
        end
        sys_rst = 1'b0; DIN = '1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_delay_line();
        test_bus_read();
        test_ecc_cpu_write();
        test_priority();
        test_abort_wait();
        test_mem_off();
        test_clear_in_ready(1'b0);
        test_clear_in_ready(1'b1);
        test_dl_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
